// File: rtl/xoodyak_ise_stage.sv
// Xoodyak RV32 ISE execute stage. It decodes custom-0 ROLI/ANDN, computes the
// result and holds it in one output register under valid/ready handshakes.
module xoodyak_ise_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_rd,
    output logic [4:0]       out_rd_addr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        OP_ILLEGAL,
        OP_ROLI,
        OP_ANDN
    } op_e;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] F7_ISE      = 7'b0000000;
    localparam logic [2:0] F3_ROLI     = 3'b001;
    localparam logic [2:0] F3_ANDN     = 3'b010;

    op_e         op;
    logic [4:0]  shamt;
    logic [31:0] rot;
    logic [31:0] result;
    logic        fire_in;
    logic        fire_out;

    // The rs1 register-index field is resolved upstream; only its value arrives here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    // NOTE: every signal written in always_comb is given a default first, so no path infers a latch.
    always_comb begin
        op = OP_ILLEGAL;
        if (in_instr[6:0] == OPC_CUSTOM0 && in_instr[31:25] == F7_ISE) begin
            case (in_instr[14:12])
                F3_ROLI: op = OP_ROLI;
                F3_ANDN: op = OP_ANDN;
                default: op = OP_ILLEGAL;
            endcase
        end
    end

    // A right shift by 32 yields zero, so shamt 0 returns rs1 unchanged.
    assign shamt = in_instr[24:20];
    assign rot   = (in_rs1 << shamt) | (in_rs1 >> (6'd32 - {1'b0, shamt}));

    always_comb begin
        result = '0;
        case (op)
            OP_ROLI: result = rot;
            OP_ANDN: result = in_rs1 & ~in_rs2;
            default: result = '0;
        endcase
    end

    assign in_ready = !flush && (!out_valid || out_ready);
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset as well, so the outputs read zero after reset.
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_rd_addr <= '0;
            out_illegal <= 1'b0;
            retired     <= '0;
        end else begin
            if (fire_out && !out_illegal) begin
                retired <= retired + CNT_W'(1);
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (fire_in) begin
                out_valid   <= 1'b1;
                out_rd      <= result;
                out_rd_addr <= in_instr[11:7];
                out_illegal <= (op == OP_ILLEGAL);
            end else if (fire_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xoodyak_ise_stage.sv
// Scoreboard bench for xoodyak_ise_stage: the driver pushes model results and
// the monitor checks every cycle against them, on 32-bit and 2-bit counter instances.
module tb_xoodyak_ise_stage;

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  addr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_rd;
    logic [4:0]  out_rd_addr;
    logic [31:0] retired;

    logic        in_ready2, out_valid2, out_illegal2;
    logic [31:0] out_rd2;
    logic [4:0]  out_rd_addr2;
    logic [1:0]  retired2;

    exp_t        sb_q[$];
    logic [31:0] ret_model = '0;
    int          checks = 0;
    int          errors = 0;
    int          mode = 0;

    always #5 clk = ~clk;

    xoodyak_ise_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rd_addr(out_rd_addr),
        .out_illegal(out_illegal), .retired(retired)
    );

    xoodyak_ise_stage #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_rd(out_rd2), .out_rd_addr(out_rd_addr2),
        .out_illegal(out_illegal2), .retired(retired2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the instruction semantics, with rotation done one bit at a time.
    function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] rs1,
                                       input logic [31:0] rs2);
        exp_t        e;
        logic [31:0] r;
        e.addr = instr[11:7];
        e.rd   = '0;
        e.ill  = 1'b1;
        if (instr[6:0] == 7'b0001011 && instr[31:25] == 7'b0000000) begin
            if (instr[14:12] == 3'b001) begin
                r = rs1;
                for (int k = 0; k < int'(instr[24:20]); k++) r = {r[30:0], r[31]};
                e.rd  = r;
                e.ill = 1'b0;
            end else if (instr[14:12] == 3'b010) begin
                e.rd  = rs1 & ~rs2;
                e.ill = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] f5,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {f7, f5, 5'd3, f3, rd, 7'b0001011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0, 1:    w = mk(7'd0, w[24:20], 3'b001, w[11:7]);
            2:       w = mk(7'd0, w[24:20], 3'b010, w[11:7]);
            3:       w = mk(7'd0, w[24:20], w[14:12], w[11:7]);
            default: w = w;
        endcase
        return w;
    endfunction

    // Driver: hold the packet until accepted, then push its expected result.
    task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = instr;
        in_rs1   = rs1;
        in_rs2   = rs2;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #3;
            if (in_ready && !rst) begin
                sb_q.push_back(ref_model(instr, rs1, rs2));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted instr=%h", instr);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
    endtask

    // Downstream: 0 always ready, 1 pattern 1,0,0,1,1, 2 never ready, 3 random.
    initial begin
        int          idx;
        int          prev_mode;
        logic [4:0]  pat;
        pat       = 5'b11001;
        idx       = 0;
        prev_mode = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (mode != prev_mode) idx = 0;
            prev_mode = mode;
            case (mode)
                1:       begin out_ready = pat[idx % 5]; idx++; end
                2:       out_ready = 1'b0;
                3:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: the queue is the model of the output register contents.
    initial begin
        bit   was_rst;
        bit   exp_v;
        exp_t h;
        was_rst = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                sb_q.delete();
                ret_model = '0;
                was_rst   = 1'b1;
                continue;
            end
            exp_v = (sb_q.size() != 0);
            check("out_valid", out_valid, exp_v);
            check("out_valid_w2", out_valid2, exp_v);
            check("in_ready", in_ready, !flush && (!exp_v || out_ready));
            check("in_ready_w2", in_ready2, !flush && (!exp_v || out_ready));
            if (was_rst) begin
                check("rst_out_rd", out_rd, 32'h0);
                check("rst_out_rd_addr", out_rd_addr, 32'h0);
                check("rst_out_illegal", out_illegal, 32'h0);
            end
            was_rst = 1'b0;
            check("retired", retired, ret_model);
            check("retired_w2", retired2, ret_model[1:0]);
            if (exp_v) begin
                h = sb_q[0];
                check("out_rd", out_rd, h.rd);
                check("out_rd_addr", out_rd_addr, h.addr);
                check("out_illegal", out_illegal, h.ill);
                check("out_rd_w2", out_rd2, h.rd);
                check("out_rd_addr_w2", out_rd_addr2, h.addr);
                check("out_illegal_w2", out_illegal2, h.ill);
                if (out_ready) begin
                    if (!h.ill) ret_model++;
                    void'(sb_q.pop_front());
                end else if (flush) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed encodings, including shamt edges and illegal forms.
        mode = 0;
        send(mk(7'd0, 5'd8, 3'b001, 5'd1), 32'h12345678, 32'h0);
        send(mk(7'd0, 5'd9, 3'b010, 5'd5), 32'hFFFF0000, 32'h0F0F0F0F);
        send(mk(7'd0, 5'd0, 3'b001, 5'd2), 32'h80000001, 32'h0);
        send(mk(7'd0, 5'd31, 3'b001, 5'd3), 32'h80000001, 32'h0);
        send(mk(7'd0, 5'd1, 3'b001, 5'd4), 32'h80000001, 32'h0);
        send(mk(7'd0, 5'd4, 3'b011, 5'd6), 32'hDEADBEEF, 32'h1);
        send(mk(7'd1, 5'd4, 3'b001, 5'd7), 32'hDEADBEEF, 32'h1);
        idle(3);

        // Back-to-back packets under a toggling out_ready.
        mode = 1;
        send(mk(7'd0, 5'd4, 3'b001, 5'd8), 32'hA5A5A5A5, 32'h0);
        send(mk(7'd0, 5'd0, 3'b010, 5'd9), 32'h12345678, 32'h000000FF);
        send(mk(7'd0, 5'd16, 3'b001, 5'd10), 32'h0000FFFF, 32'h0);
        send(mk(7'd0, 5'd0, 3'b010, 5'd11), 32'hFFFFFFFF, 32'hAAAAAAAA);
        idle(4);
        mode = 0;
        idle(2);

        // Flush a stalled packet, then flush coinciding with hand-off.
        mode = 2;
        send(mk(7'd0, 5'd3, 3'b001, 5'd12), 32'h11111111, 32'h0);
        idle(2);
        flush_pulse();
        mode = 0;
        idle(2);
        send(mk(7'd0, 5'd5, 3'b001, 5'd13), 32'h22222222, 32'h0);
        flush_pulse();
        idle(2);

        // Reset while holding a packet; packets offered during reset are ignored.
        mode = 2;
        send(mk(7'd0, 5'd7, 3'b001, 5'd14), 32'h33333333, 32'h0);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(7'd0, 5'd2, 3'b001, 5'd15);
        repeat (2) @(posedge clk);
        #1 rst   = 1'b0;
        in_valid = 1'b0;
        mode = 0;
        idle(2);

        // Randomized traffic with random backpressure and flushes.
        mode = 3;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) send(rand_instr(), $urandom, $urandom);
            else if (r < 9) idle(1);
            else flush_pulse();
        end

        mode = 0;
        idle(2);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", sb_q.size(), 32'h0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
